// File: rtl/bus_arb4_rr.sv
// Four-master round-robin arbiter onto one valid/ready slave port.
// Granted transactions that stall past TIMEOUT cycles are completed with ERR_DATA and logged.
module bus_arb4_rr #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [3:0]   m_valid,
  output logic [3:0]   m_ready,
  input  logic [127:0] m_addr,
  input  logic [127:0] m_wdata,
  input  logic [15:0]  m_wstrb,
  output logic [31:0]  m_rdata,
  output logic         s_valid,
  input  logic         s_ready,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  output logic [3:0]   s_wstrb,
  input  logic [31:0]  s_rdata,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         timeout_irq,
  output logic [1:0]   timeout_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] WD_LIM = 16'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic [1:0]         ptr, ptr_nx, grant_nx;
  logic [15:0]        wdog, wdog_nx;
  logic [3:0][31:0]   addr_a, wdata_a;
  logic [3:0][3:0]    wstrb_a;
  logic [3:0]         grant_oh, req;
  logic               gv, ok_done, to_done, done;
  logic [1:0]         sel, idx;
  logic               found;

  assign addr_a   = m_addr;
  assign wdata_a  = m_wdata;
  assign wstrb_a  = m_wstrb;
  assign grant_oh = 4'b0001 << grant;
  assign busy     = (state == BUSY);
  assign gv       = busy && m_valid[grant];

  // s_ready on the limit cycle wins over the watchdog
  assign ok_done  = gv && s_ready;
  assign to_done  = gv && !s_ready && (wdog == WD_LIM);
  assign done     = ok_done || to_done;

  assign s_valid  = gv && !to_done;
  assign s_addr   = busy ? addr_a[grant]  : 32'h0;
  assign s_wdata  = busy ? wdata_a[grant] : 32'h0;
  assign s_wstrb  = busy ? wstrb_a[grant] : 4'h0;
  assign m_ready  = done ? grant_oh : 4'b0000;
  assign m_rdata  = to_done ? ERR_DATA : s_rdata;

  // Completing master is masked so the rotation moves on without an idle bubble
  assign req = (state == IDLE) ? m_valid : (done ? (m_valid & ~grant_oh) : 4'b0000);

  always_comb begin
    sel   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx   = ptr;
    wdog_nx  = wdog;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = BUSY;
          grant_nx = sel;
          ptr_nx   = sel + 2'd1;
          wdog_nx  = 16'd0;
        end
      end
      BUSY: begin
        if (done) begin
          if (found) begin
            grant_nx = sel;
            ptr_nx   = sel + 2'd1;
            wdog_nx  = 16'd0;
          end else begin
            state_nx = IDLE;
          end
        end else if (!m_valid[grant]) begin
          state_nx = IDLE;
        end else begin
          wdog_nx = wdog + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      grant       <= 2'd0;
      wdog        <= 16'd0;
      timeout_irq <= 1'b0;
      timeout_id  <= 2'd0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      grant       <= grant_nx;
      wdog        <= wdog_nx;
      timeout_irq <= to_done;
      if (to_done) timeout_id <= grant;
    end
  end

endmodule

// File: tb/tb_bus_arb4_rr.sv
// Directed bench for bus_arb4_rr with TIMEOUT=8: stimulus pushes expected completions,
// a negedge monitor pops and compares whenever any m_ready bit is seen.
module tb_bus_arb4_rr;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   m_valid, m_ready;
  logic [127:0] m_addr, m_wdata;
  logic [15:0]  m_wstrb;
  logic [31:0]  m_rdata;
  logic         s_valid, s_ready;
  logic [31:0]  s_addr, s_wdata, s_rdata;
  logic [3:0]   s_wstrb;
  logic [1:0]   grant, timeout_id;
  logic         busy, timeout_irq;

  bus_arb4_rr #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .busy(busy), .timeout_irq(timeout_irq), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          comp_cnt = 0;
  int          dly = 0;
  int          bcnt = 0;
  logic [31:0] rdata_val = 32'h0;
  logic [3:0]  persist = 4'b0;
  logic [3:0]  rel_mask = 4'b0;
  logic        prev_busy = 1'b0;
  logic        last_done = 1'b0;
  logic        pend_chk = 1'b0;
  logic        pend_to = 1'b0;
  logic [1:0]  pend_id = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic push(input int id, input logic [31:0] rd, input logic to, input int cyc);
    exp_t e;
    e.id = id; e.rdata = rd; e.to = to; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic set_master(input int i, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws);
    m_addr[32*i +: 32]  = a;
    m_wdata[32*i +: 32] = wd;
    m_wstrb[4*i +: 4]   = ws;
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (comp_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(comp_cnt >= target), 32'd1);
  endtask

  // Slave: asserts s_ready on the dly-th cycle of each granted transaction (dly=0: never)
  always @(negedge clk) begin
    if (!resetn || !busy) bcnt = 0;
    else if (last_done || !prev_busy) bcnt = 1;
    else bcnt = bcnt + 1;
    prev_busy = busy && resetn;
    s_ready   = busy && (dly != 0) && (bcnt == dly);
    s_rdata   = rdata_val;
  end

  // Masters drop valid the edge after their completion unless held persistent
  always @(posedge clk) begin
    #1;
    m_valid  = m_valid & ~rel_mask;
    rel_mask = 4'b0;
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!resetn) begin
      pend_chk  = 1'b0;
      last_done = 1'b0;
    end else begin
      if (pend_chk) begin
        chk("timeout_irq after completion", 32'(timeout_irq), 32'(pend_to));
        if (pend_to) chk("timeout_id", 32'(timeout_id), 32'(pend_id));
        pend_chk = 1'b0;
      end else if (timeout_irq) begin
        chk("spurious timeout_irq", 32'(timeout_irq), 32'd0);
      end
      if (|m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected m_ready", 32'(m_ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("m_ready onehot", 32'(m_ready), 32'(4'b0001 << e.id));
          chk("grant at completion", 32'(grant), 32'(e.id));
          chk("m_rdata", m_rdata, e.rdata);
          chk("s_valid at completion", 32'(s_valid), 32'(!e.to));
          chk("completion cycle", 32'(bcnt), 32'(e.cyc));
          pend_chk = 1'b1;
          pend_to  = e.to;
          pend_id  = 2'(e.id);
        end
        rel_mask = rel_mask | (m_ready & ~persist);
        comp_cnt++;
      end
      last_done = |m_ready;
    end
  end

  initial begin
    int base;
    logic idle_seen;
    resetn = 1'b0; m_valid = 4'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
    for (int i = 0; i < 4; i++)
      set_master(i, 32'h100 * (i + 1), 32'h1111_0000 + i, 4'h0);
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset s_valid", 32'(s_valid), 32'd0);
    chk("reset m_ready", 32'(m_ready), 32'd0);
    chk("reset s_addr", s_addr, 32'd0);
    chk("reset timeout_irq", 32'(timeout_irq), 32'd0);
    chk("reset timeout_id", 32'(timeout_id), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // All four continuously: 0,1,2,3 then each once more as they release
    dly = 1; rdata_val = 32'hA0A0_0001; persist = 4'b1111;
    base = comp_cnt;
    for (int k = 0; k < 8; k++) push(k % 4, rdata_val, 1'b0, 1);
    m_valid = 4'b1111;
    idle_seen = 1'b0;
    for (int n = 0; n < 40 && comp_cnt < base + 8; n++) begin
      tick();
      if (comp_cnt > base && comp_cnt < base + 8 && !busy) idle_seen = 1'b1;
      if (comp_cnt >= base + 4) persist = 4'b0;
    end
    chk("rr4 all done", 32'(comp_cnt), 32'(base + 8));
    chk("rr4 no idle bubble", 32'(idle_seen), 32'd0);
    tick();

    // Single master 2 write, slave ready on third s_valid cycle
    dly = 3; rdata_val = 32'h0BAD_F00D;
    set_master(2, 32'h1000, 32'hCAFE_F00D, 4'hF);
    push(2, rdata_val, 1'b0, 3);
    m_valid = 4'b0100;
    #1;
    chk("no comb valid path", 32'(s_valid), 32'd0);
    tick();
    chk("single busy", 32'(busy), 32'd1);
    chk("single grant", 32'(grant), 32'd2);
    chk("single s_valid", 32'(s_valid), 32'd1);
    chk("single s_addr", s_addr, 32'h1000);
    chk("single s_wdata", s_wdata, 32'hCAFE_F00D);
    chk("single s_wstrb", 32'(s_wstrb), 32'hF);
    wait_done("single done", comp_cnt + 1, 20);
    tick();

    // Master 3 alone, then 1 and 3 contend: 1,3,1,3
    dly = 1; rdata_val = 32'h3333_0001;
    push(3, rdata_val, 1'b0, 1);
    m_valid = 4'b1000;
    wait_done("m3 solo done", comp_cnt + 1, 20);
    base = comp_cnt;
    push(1, rdata_val, 1'b0, 1); push(3, rdata_val, 1'b0, 1);
    push(1, rdata_val, 1'b0, 1); push(3, rdata_val, 1'b0, 1);
    persist = 4'b1010;
    m_valid = m_valid | 4'b1010;
    for (int n = 0; n < 30 && comp_cnt < base + 4; n++) begin
      tick();
      if (comp_cnt >= base + 2) persist = 4'b0;
    end
    chk("m1m3 done", 32'(comp_cnt), 32'(base + 4));
    tick();

    // Watchdog: slave never answers master 1 read
    dly = 0;
    set_master(1, 32'h2000, 32'h0, 4'h0);
    push(1, 32'hDEADBEEF, 1'b1, 8);
    m_valid = 4'b0010;
    wait_done("timeout done", comp_cnt + 1, 30);
    tick(); tick();

    // s_ready lands exactly on the limit cycle: normal completion
    dly = 8; rdata_val = 32'h1234_5678;
    push(2, rdata_val, 1'b0, 8);
    m_valid = 4'b0100;
    wait_done("limit ready done", comp_cnt + 1, 30);
    tick(); tick();
    chk("timeout_id sticky", 32'(timeout_id), 32'd1);

    // Async reset mid-transaction
    dly = 0;
    m_valid = 4'b1000;
    tick(); tick();
    chk("pre-reset busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("async rst s_valid", 32'(s_valid), 32'd0);
    chk("async rst m_ready", 32'(m_ready), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst grant", 32'(grant), 32'd0);
    tick();
    dly = 1; rdata_val = 32'h5555_AAAA; persist = 4'b0; rel_mask = 4'b0;
    push(0, rdata_val, 1'b0, 1); push(3, rdata_val, 1'b0, 1);
    m_valid = 4'b1001;
    resetn = 1'b1;
    wait_done("post-reset done", comp_cnt + 2, 20);
    tick(); tick();
    chk("queue drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
